// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported, fixed-latency unified memory between the fetch
// and memory stages. Ties are broken round-robin, and one access is in flight at a time.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_rdy,
   output logic [DATA_W-1:0] i_data,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_rdy,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam logic [3:0] LatCnt = 4'(MEM_LAT);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       last_grant;
   logic       lat_we;
   logic       i_elig;
   logic       d_elig;
   logic       grant_d;
   logic       grant_i;

   // A port in its rdy cycle has just been served and sits out this arbitration.
   assign i_elig  = i_req & ~i_rdy;
   assign d_elig  = d_req & ~d_rdy;
   assign grant_d = d_elig & (~i_elig | ~last_grant);
   assign grant_i = i_elig & ~grant_d;

   assign mem_we    = mem_en & lat_we;
   assign stall_if  = i_req & ~i_rdy;
   assign stall_mem = d_req & ~d_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         cnt        <= '0;
         last_grant <= 1'b0;
         lat_we     <= 1'b0;
         i_rdy      <= 1'b0;
         d_rdy      <= 1'b0;
         i_data     <= '0;
         d_rdata    <= '0;
         mem_en     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         i_rdy  <= 1'b0;
         d_rdy  <= 1'b0;
         mem_en <= 1'b0;
         unique case (state)
            StIdle: begin
               if (grant_d) begin
                  state      <= StBusyD;
                  cnt        <= LatCnt;
                  last_grant <= 1'b1;
                  mem_en     <= 1'b1;
                  lat_we     <= d_we;
                  mem_addr   <= d_addr;
                  mem_wdata  <= d_wdata;
               end else if (grant_i) begin
                  state      <= StBusyI;
                  cnt        <= LatCnt;
                  last_grant <= 1'b0;
                  mem_en     <= 1'b1;
                  lat_we     <= 1'b0;
                  mem_addr   <= i_addr;
               end
            end
            StBusyI, StBusyD: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= StIdle;
                  if (state == StBusyI) begin
                     i_data <= mem_rdata;
                     i_rdy  <= 1'b1;
                  end else begin
                     if (!lat_we) d_rdata <= mem_rdata;
                     d_rdy <= 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of grants, latency and data.
module tb_mem_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_rdy;
   logic [15:0] i_data;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_rdy;
   logic [15:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem [256];
   logic [15:0] ref_mem [256];
   logic        mem_load;

   mem_arbiter #(
      .ADDR_W (16),
      .DATA_W (16),
      .MEM_LAT(LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_rdy    (i_rdy),
      .i_data   (i_data),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdy    (d_rdy),
      .d_rdata  (d_rdata),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .stall_if (stall_if),
      .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_word(int a);
      logic [15:0] w;
      if (a == 16) return 16'hB123;
      w = 16'(a) * 16'h01F1;
      return w ^ 16'hA5C3;
   endfunction

   // Memory model: address held stable for the whole access, so read data is combinational.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[7:0]];

   task automatic test_single_fetch();
      i_req  = 1'b1;
      i_addr = 16'h0010;
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clk);
         total++;
         if (mem_en !== (k == 1)) begin
            bad++; $display("FAIL fetch_mem_en k=%0d got=%b want=%b", k, mem_en, (k == 1));
         end
         total++;
         if (i_rdy !== (k == LAT + 1)) begin
            bad++; $display("FAIL fetch_i_rdy k=%0d got=%b want=%b", k, i_rdy, (k == LAT + 1));
         end
         total++;
         if (stall_if !== (k != LAT + 1)) begin
            bad++; $display("FAIL fetch_stall_if k=%0d got=%b want=%b", k, stall_if,
                            (k != LAT + 1));
         end
         if (k == 1) begin
            total++;
            if (mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
               bad++; $display("FAIL fetch_mem_addr got=%h/%b want=0010/0", mem_addr, mem_we);
            end
         end
      end
      total++;
      if (i_data !== 16'hB123) begin
         bad++; $display("FAIL fetch_i_data got=%h want=b123", i_data);
      end
      i_req = 1'b0;
      @(negedge clk);
      total++;
      if (i_rdy !== 1'b0 || mem_en !== 1'b0) begin
         bad++; $display("FAIL fetch_after got=%b/%b want=0/0", i_rdy, mem_en);
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      i_req  = 1'b1;
      i_addr = 16'h0010;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total++;
         if ({i_rdy, d_rdy, mem_en, mem_we} !== 4'b0 || i_data !== 16'h0 || d_rdata !== 16'h0 ||
             mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            bad++; $display("FAIL reset_outputs k=%0d got=%b%b%b%b %h %h %h %h want=all 0", k,
                            i_rdy, d_rdy, mem_en, mem_we, i_data, d_rdata, mem_addr, mem_wdata);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clk);
         total++;
         if (mem_en !== (k == 1) || i_rdy !== (k == LAT + 1)) begin
            bad++; $display("FAIL reset_release k=%0d got=%b/%b want=%b/%b", k, mem_en, i_rdy,
                            (k == 1), (k == LAT + 1));
         end
         if (k == 1) begin
            total++;
            if (mem_addr !== 16'h0010) begin
               bad++; $display("FAIL reset_release_addr got=%h want=0010", mem_addr);
            end
         end
      end
      i_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_tie();
      int  g;
      logic exp_en, exp_own_d, exp_irdy, exp_drdy;
      rst    = 1'b1;
      i_req  = 1'b1;
      i_addr = 16'h0030;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 16'h0040;
      @(negedge clk);
      rst = 1'b0;
      for (int t = 1; t <= 4 * (LAT + 1); t++) begin
         @(negedge clk);
         g         = (t - 1) / (LAT + 1);
         exp_en    = ((t - 1) % (LAT + 1)) == 0;
         exp_own_d = (g % 2) == 0;
         exp_drdy  = (t % (LAT + 1)) == 0 && exp_own_d;
         exp_irdy  = (t % (LAT + 1)) == 0 && !exp_own_d;
         total++;
         if (mem_en !== exp_en) begin
            bad++; $display("FAIL tie_mem_en t=%0d got=%b want=%b", t, mem_en, exp_en);
         end
         if (exp_en) begin
            total++;
            if (mem_addr !== (exp_own_d ? 16'h0040 : 16'h0030)) begin
               bad++; $display("FAIL tie_order t=%0d got=%h want=%h", t, mem_addr,
                               (exp_own_d ? 16'h0040 : 16'h0030));
            end
         end
         total++;
         if (d_rdy !== exp_drdy || i_rdy !== exp_irdy) begin
            bad++; $display("FAIL tie_rdy t=%0d got=%b/%b want=%b/%b", t, d_rdy, i_rdy, exp_drdy,
                            exp_irdy);
         end
         if (exp_drdy) begin
            total++;
            if (d_rdata !== ref_mem[8'h40]) begin
               bad++; $display("FAIL tie_d_rdata got=%h want=%h", d_rdata, ref_mem[8'h40]);
            end
         end
         if (exp_irdy) begin
            total++;
            if (i_data !== ref_mem[8'h30]) begin
               bad++; $display("FAIL tie_i_data got=%h want=%h", i_data, ref_mem[8'h30]);
            end
         end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 16'h0020;
      d_wdata = 16'h55AA;
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clk);
         total++;
         if (mem_en !== (k == 1) || mem_we !== (k == 1)) begin
            bad++; $display("FAIL store_strobe k=%0d got=%b/%b want=%b", k, mem_en, mem_we,
                            (k == 1));
         end
         if (k <= LAT) begin
            total++;
            if (mem_addr !== 16'h0020 || mem_wdata !== 16'h55AA) begin
               bad++; $display("FAIL store_bus k=%0d got=%h/%h want=0020/55aa", k, mem_addr,
                               mem_wdata);
            end
         end
         total++;
         if (d_rdy !== (k == LAT + 1)) begin
            bad++; $display("FAIL store_d_rdy k=%0d got=%b want=%b", k, d_rdy, (k == LAT + 1));
         end
         total++;
         if (d_rdata !== ref_mem[8'h40]) begin
            bad++; $display("FAIL store_d_rdata k=%0d got=%h want=%h", k, d_rdata, ref_mem[8'h40]);
         end
      end
      ref_mem[8'h20] = 16'h55AA;
      d_req = 1'b0;
      d_we  = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_busy_request();
      i_req  = 1'b1;
      i_addr = 16'h0050;
      @(negedge clk);
      total++;
      if (mem_en !== 1'b1 || mem_addr !== 16'h0050) begin
         bad++; $display("FAIL busy_fetch_issue got=%b/%h want=1/0050", mem_en, mem_addr);
      end
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 16'h0020;
      for (int k = 2; k <= LAT + 1; k++) begin
         @(negedge clk);
         total++;
         if (stall_mem !== 1'b1 || mem_en !== 1'b0 || d_rdy !== 1'b0) begin
            bad++; $display("FAIL busy_wait k=%0d got=%b/%b/%b want=1/0/0", k, stall_mem, mem_en,
                            d_rdy);
         end
         total++;
         if (i_rdy !== (k == LAT + 1)) begin
            bad++; $display("FAIL busy_i_rdy k=%0d got=%b want=%b", k, i_rdy, (k == LAT + 1));
         end
      end
      total++;
      if (i_data !== ref_mem[8'h50]) begin
         bad++; $display("FAIL busy_i_data got=%h want=%h", i_data, ref_mem[8'h50]);
      end
      i_req = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clk);
         total++;
         if (mem_en !== (k == 1) || d_rdy !== (k == LAT + 1) || stall_mem !== (k != LAT + 1))
         begin
            bad++; $display("FAIL busy_load k=%0d got=%b/%b/%b want=%b/%b/%b", k, mem_en, d_rdy,
                            stall_mem, (k == 1), (k == LAT + 1), (k != LAT + 1));
         end
         if (k == 1) begin
            total++;
            if (mem_addr !== 16'h0020) begin
               bad++; $display("FAIL busy_load_addr got=%h want=0020", mem_addr);
            end
         end
      end
      total++;
      if (d_rdata !== 16'h55AA) begin
         bad++; $display("FAIL busy_load_data got=%h want=55aa", d_rdata);
      end
      d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      i_req  = 1'b1;
      i_addr = 16'h0070;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (k == 1) begin
            total++;
            if (mem_en !== 1'b1) begin
               bad++; $display("FAIL mid_issue got=%b want=1", mem_en);
            end
         end
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (i_rdy !== 1'b0 || mem_en !== 1'b0 || i_data !== 16'h0) begin
         bad++; $display("FAIL mid_abandon got=%b/%b/%h want=0/0/0000", i_rdy, mem_en, i_data);
      end
      rst = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clk);
         total++;
         if (mem_en !== (k == 1) || i_rdy !== (k == LAT + 1)) begin
            bad++; $display("FAIL mid_rearb k=%0d got=%b/%b want=%b/%b", k, mem_en, i_rdy,
                            (k == 1), (k == LAT + 1));
         end
         if (k == 1) begin
            total++;
            if (mem_addr !== 16'h0070) begin
               bad++; $display("FAIL mid_rearb_addr got=%h want=0070", mem_addr);
            end
         end
      end
      total++;
      if (i_data !== ref_mem[8'h70]) begin
         bad++; $display("FAIL mid_i_data got=%h want=%h", i_data, ref_mem[8'h70]);
      end
      i_req = 1'b0;
      @(negedge clk);
   endtask

   // Transaction model: one access at a time, LAT busy cycles from the strobe, rdy right after.
   task automatic test_random();
      int          c, en_cyc;
      logic        m_last, m_own_d, m_we, er_i, er_d, exp_en, busy;
      logic [15:0] m_addr, m_wd, m_rd, m_idata, m_drdata;
      logic        p_free, p_ie, p_de, p_dwe;
      logic [15:0] p_ia, p_da, p_dwd;
      rst   = 1'b1;
      i_req = 1'b0;
      d_req = 1'b0;
      @(negedge clk);
      rst      = 1'b0;
      c        = 0;
      en_cyc   = -1000;
      m_last   = 1'b0;
      m_own_d  = 1'b0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_wd     = '0;
      m_rd     = '0;
      m_idata  = '0;
      m_drdata = '0;
      p_free   = 1'b1;
      p_ie     = 1'b0;
      p_de     = 1'b0;
      p_dwe    = 1'b0;
      p_ia     = '0;
      p_da     = '0;
      p_dwd    = '0;
      for (int n = 0; n < 1500; n++) begin
         @(posedge clk);
         #1;
         if (!i_req || i_rdy) begin
            i_req  = ($urandom_range(0, 2) != 0);
            i_addr = 16'($urandom);
         end
         if (!d_req || d_rdy) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = ($urandom_range(0, 2) == 0);
            d_addr  = 16'($urandom);
            d_wdata = 16'($urandom);
         end
         @(negedge clk);
         c++;
         exp_en = p_free && (p_ie || p_de);
         total++;
         if (mem_en !== exp_en) begin
            bad++; $display("FAIL rnd_mem_en c=%0d got=%b want=%b", c, mem_en, exp_en);
         end
         if (exp_en) begin
            m_own_d = p_de && (!p_ie || !m_last);
            m_last  = m_own_d;
            en_cyc  = c;
            m_addr  = m_own_d ? p_da : p_ia;
            m_we    = m_own_d && p_dwe;
            m_wd    = p_dwd;
            if (m_we) ref_mem[m_addr[7:0]] = m_wd;
            else      m_rd = ref_mem[m_addr[7:0]];
         end
         total++;
         if (mem_we !== (exp_en && m_we)) begin
            bad++; $display("FAIL rnd_mem_we c=%0d got=%b want=%b", c, mem_we, (exp_en && m_we));
         end
         busy = (c >= en_cyc) && (c < en_cyc + LAT);
         if (busy) begin
            total++;
            if (mem_addr !== m_addr || (m_we && mem_wdata !== m_wd)) begin
               bad++; $display("FAIL rnd_mem_bus c=%0d got=%h/%h want=%h/%h", c, mem_addr,
                               mem_wdata, m_addr, m_wd);
            end
         end
         er_i = (c == en_cyc + LAT) && !m_own_d;
         er_d = (c == en_cyc + LAT) && m_own_d;
         if (er_i) m_idata = m_rd;
         if (er_d && !m_we) m_drdata = m_rd;
         total++;
         if (i_rdy !== er_i || d_rdy !== er_d) begin
            bad++; $display("FAIL rnd_rdy c=%0d got=%b/%b want=%b/%b", c, i_rdy, d_rdy, er_i, er_d);
         end
         total++;
         if (i_data !== m_idata || d_rdata !== m_drdata) begin
            bad++; $display("FAIL rnd_data c=%0d got=%h/%h want=%h/%h", c, i_data, d_rdata,
                            m_idata, m_drdata);
         end
         total++;
         if (stall_if !== (i_req && !er_i) || stall_mem !== (d_req && !er_d)) begin
            bad++; $display("FAIL rnd_stall c=%0d got=%b/%b want=%b/%b", c, stall_if, stall_mem,
                            (i_req && !er_i), (d_req && !er_d));
         end
         p_free = !busy;
         p_ie   = i_req && !er_i;
         p_de   = d_req && !er_d;
         p_ia   = i_addr;
         p_da   = d_addr;
         p_dwe  = d_we;
         p_dwd  = d_wdata;
      end
      i_req = 1'b0;
      d_req = 1'b0;
      repeat (LAT + 2) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      mem_load = 1'b1;
      rst      = 1'b1;
      i_req    = 1'b0;
      i_addr   = '0;
      d_req    = 1'b0;
      d_we     = 1'b0;
      d_addr   = '0;
      d_wdata  = '0;
      repeat (2) @(negedge clk);
      mem_load = 1'b0;
      rst      = 1'b0;
      test_single_fetch();
      test_reset();
      test_tie();
      test_store();
      test_busy_request();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
